sb_cpu_bridge: RTL

- CPU-side bridge that converts single-cycle 6502-style register accesses into system-bus (wishbone-style) strobe/ack transactions for the SB_SPI/SB_I2C hard IP.
- Stalls the CPU through a low-true rdy until the hard IP acknowledges the transfer.
- Sits directly upstream of the system-bus IP cores; its sb_* outputs drive the hard-IP SBSTBI/SBADRI/SBRWI/SBDATI pins, and its sb_* inputs are fed from SBDATO/SBACKO.
- Adds a bounded-wait timeout so that an unmapped address never hangs the CPU.

---
 rtl/sb_cpu_bridge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sb_cpu_bridge.sv
// CPU-to-system-bus bridge: 3+ cycles per access; stalls the CPU via rdy until ack,
// or aborts after TIMEOUT strobe cycles with an err pulse and ERR_DATA on reads.
module sb_cpu_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       sb_stbo,
  output logic       sb_rwo,
  output logic [7:0] sb_adro,
  output logic [7:0] sb_dato,
  input  logic       sb_acki,
  input  logic [7:0] sb_dati,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       stb_q, stb_d;
  logic       rw_q, rw_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] dout_q, dout_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      rw_q    <= 1'b0;
      adr_q   <= 8'h00;
      dat_q   <= 8'h00;
      dout_q  <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      rw_q    <= rw_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    rw_d    = rw_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cs) begin
          adr_d   = addr;
          rw_d    = we;
          dat_d   = din;
          cnt_d   = 8'h00;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is tested first so it beats a coincident terminal count.
        if (sb_acki) begin
          stb_d   = 1'b0;
          if (!rw_q) dout_d = sb_dati;
          state_d = DONE;
        end else if (cnt_q == TERM_CNT) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          if (!rw_q) dout_d = ERR_DATA;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign rdy     = !rst ? 1'b1 : !(cs && (state_q != DONE));
  assign sb_stbo = stb_q;
  assign sb_rwo  = rw_q;
  assign sb_adro = adr_q;
  assign sb_dato = dat_q;
  assign dout    = dout_q;
  assign err     = err_q;

  a_stb_only_in_bus: assert property (@(posedge clk) disable iff (!rst)
    stb_q |-> (state_q == BUS));
  a_err_only_in_done: assert property (@(posedge clk) disable iff (!rst)
    err_q |-> (state_q == DONE));

endmodule
